cpu_run_ctrl: RTL and testbench

Run/halt/step controller for the single-cycle CPU. It produces the commit enable `cpu_en`, which gates the state updates of the program counter, the register-file write and the data-memory write. It also accepts host commands to run, halt and single/multi-step the core. It stops the core on a PC breakpoint or a `syscall` instruction and counts retired instructions. It sits beside the CPU top level, observes the fetched `pc` and `instr`, and is the only source of `cpu_en`.

---
 rtl/cpu_run_ctrl.sv | 85 ++++++++
 tb/tb_cpu_run_ctrl.sv | 122 ++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/halt/step controller producing the CPU commit enable, with breakpoint/syscall stops and a retired counter.
module cpu_run_ctrl #(
  parameter int CNT_W  = 32,
  parameter int STEP_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_op,
  input  logic [STEP_W-1:0] cmd_count,
  output logic              cmd_ready,
  output logic              cmd_err,
  input  logic              bp_en,
  input  logic [31:0]       bp_addr,
  input  logic              cnt_clr,
  input  logic [31:0]       pc,
  input  logic [31:0]       instr,
  output logic              cpu_en,
  output logic              halted,
  output logic [2:0]        halt_cause,
  output logic [CNT_W-1:0]  retired
);
  typedef enum logic [1:0] {S_HALTED, S_RUN, S_STEP} state_t;
  state_t r_state, w_state_nx;
  logic [STEP_W-1:0] r_steps, w_steps_nx;
  logic r_skip, w_skip_nx, r_err;
  logic [2:0] r_cause, w_cause_nx;
  logic [CNT_W-1:0] r_retired;
  logic w_active, w_bp, w_sys, w_run_cmd, w_step_cmd, w_halt_cmd, w_step_done, w_stop;
  assign w_active    = r_state != S_HALTED;
  assign w_bp        = bp_en && pc == bp_addr && !r_skip;
  assign w_sys       = instr == 32'h0000_000C;
  assign w_run_cmd   = cmd_valid && cmd_op == 2'b01;
  assign w_halt_cmd  = cmd_valid && cmd_op == 2'b10;
  assign w_step_cmd  = cmd_valid && cmd_op == 2'b11;
  assign cpu_en      = w_active && !reset && !w_bp && !w_sys;
  assign w_step_done = r_state == S_STEP && cpu_en && r_steps == STEP_W'(1);
  assign w_stop      = w_bp || w_sys || w_step_done || w_halt_cmd;
  assign cmd_ready   = 1'b1;
  assign cmd_err     = r_err;
  assign halted      = r_state == S_HALTED;
  assign halt_cause  = r_cause;
  assign retired     = r_retired;
  always_comb begin
    w_state_nx = r_state;
    w_steps_nx = r_steps;
    w_skip_nx  = r_skip;
    w_cause_nx = r_cause;
    if (!w_active) begin
      if (w_run_cmd) begin
        w_state_nx = S_RUN;
        w_skip_nx  = 1'b1;
      end else if (w_step_cmd) begin
        w_state_nx = S_STEP;
        w_steps_nx = cmd_count == '0 ? STEP_W'(1) : cmd_count;
        w_skip_nx  = 1'b1;
      end
    end else begin
      w_skip_nx = 1'b0;
      if (r_state == S_STEP && cpu_en) w_steps_nx = r_steps - STEP_W'(1);
      if (w_stop) begin
        w_state_nx = S_HALTED;
        w_steps_nx = '0;
        w_cause_nx = w_bp ? 3'b010 : w_sys ? 3'b100 : w_step_done ? 3'b011 : 3'b001;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_HALTED;
      r_steps   <= '0;
      r_skip    <= 1'b0;
      r_cause   <= 3'b000;
      r_err     <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_steps   <= w_steps_nx;
      r_skip    <= w_skip_nx;
      r_cause   <= w_cause_nx;
      r_err     <= w_active && (w_run_cmd || w_step_cmd);
      r_retired <= cnt_clr ? '0 : r_retired + CNT_W'(cpu_en);
    end
  end
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: scoreboard bench; a rule-level model predicts every cycle's outputs, a negedge monitor compares.
module tb_cpu_run_ctrl;
  localparam int CNT_W = 4;
  localparam logic [31:0] SYSC = 32'h0000_000C;
  localparam logic [31:0] NOPI = 32'h0000_0013;
  logic clk = 1'b0, reset = 1'b1, cmd_valid = 1'b0, bp_en = 1'b0, cnt_clr = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [15:0] cmd_count = '0;
  logic [31:0] bp_addr = '0, pc = '0, instr;
  logic cmd_ready, cmd_err, cpu_en, halted;
  logic [2:0] halt_cause;
  logic [CNT_W-1:0] retired;
  logic [31:0] imem [64];
  typedef struct packed {logic en; logic hl; logic [2:0] cause; logic [CNT_W-1:0] ret; logic err;} exp_t;
  exp_t q[$];
  int n_chk = 0, n_pass = 0;
  bit m_halted = 1'b1, m_skip = 1'b0, m_err = 1'b0;
  int m_budget = 0;
  logic [2:0] m_cause = 3'b000;
  logic [CNT_W-1:0] m_ret = '0;
  assign instr = imem[pc[7:2]];
  always #5 clk = ~clk;
  cpu_run_ctrl #(.CNT_W(CNT_W), .STEP_W(16)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_count(cmd_count),
    .cmd_ready(cmd_ready), .cmd_err(cmd_err), .bp_en(bp_en), .bp_addr(bp_addr), .cnt_clr(cnt_clr),
    .pc(pc), .instr(instr), .cpu_en(cpu_en), .halted(halted), .halt_cause(halt_cause), .retired(retired)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
  endtask
  always @(negedge clk) if (q.size() > 0) begin
    exp_t e;
    e = q.pop_front();
    chk("cpu_en", 32'(cpu_en), 32'(e.en));
    chk("halted", 32'(halted), 32'(e.hl));
    chk("halt_cause", 32'(halt_cause), 32'(e.cause));
    chk("retired", 32'(retired), 32'(e.ret));
    chk("cmd_err", 32'(cmd_err), 32'(e.err));
    chk("cmd_ready", 32'(cmd_ready), 32'd1);
  end
  // One clock: predict this cycle's outputs from the rules, then advance the model and the program counter.
  task automatic cycle(input logic v, input logic [1:0] op, input int cnt);
    bit bp, sys, en, done, is_run, is_step, is_halt;
    cmd_valid = v; cmd_op = op; cmd_count = 16'(cnt);
    is_run = v && op == 2'b01; is_step = v && op == 2'b11; is_halt = v && op == 2'b10;
    bp  = bp_en && pc == bp_addr && !m_skip;
    sys = imem[pc[7:2]] == SYSC;
    en  = !reset && !m_halted && !bp && !sys;
    q.push_back('{en, m_halted, m_cause, m_ret, m_err});
    @(posedge clk);
    #1;
    if (reset) begin
      m_halted = 1; m_cause = 3'b000; m_ret = '0; m_err = 0; m_skip = 0; m_budget = 0;
    end else begin
      m_err = (is_run || is_step) && !m_halted;
      m_ret = cnt_clr ? '0 : CNT_W'((int'(m_ret) + int'(en)) % (1 << CNT_W));
      if (m_halted) begin
        if (is_run) begin m_halted = 0; m_budget = -1; m_skip = 1; end
        else if (is_step) begin m_halted = 0; m_budget = (cnt == 0) ? 1 : cnt; m_skip = 1; end
      end else begin
        done = 0; m_skip = 0;
        if (en && m_budget > 0) begin m_budget--; done = m_budget == 0; end
        if (bp || sys || done || is_halt) begin
          m_halted = 1; m_budget = 0;
          m_cause = bp ? 3'b010 : sys ? 3'b100 : done ? 3'b011 : 3'b001;
        end
      end
    end
    if (en) pc = pc + 32'd4;
    cmd_valid = 0; cmd_op = 2'b00; cmd_count = '0;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 2'b00, 0);
  endtask
  initial begin
    for (int i = 0; i < 64; i++) imem[i] = NOPI;
    @(posedge clk); #1;
    cycle(0, 2'b00, 0);
    reset = 0;
    idle(1);
    cycle(1, 2'b11, 0); idle(3);
    pc = 0; bp_en = 1; bp_addr = 32'h10;
    cycle(1, 2'b01, 0); idle(6);
    cycle(1, 2'b01, 0); idle(3);
    cycle(1, 2'b10, 0); idle(2);
    bp_en = 0; pc = 0;
    cycle(1, 2'b11, 5); idle(2); cycle(1, 2'b10, 0); idle(2);
    imem[2] = SYSC; pc = 0;
    cycle(1, 2'b01, 0); idle(5);
    cycle(1, 2'b10, 0); idle(1);
    imem[2] = NOPI; pc = 0;
    cycle(1, 2'b01, 0); idle(2); cycle(1, 2'b01, 0); idle(2);
    reset = 1; idle(1); reset = 0; idle(2);
    pc = 0;
    cycle(1, 2'b01, 0); idle(18);
    cnt_clr = 1; idle(1); cnt_clr = 0; idle(2);
    cycle(1, 2'b10, 0); idle(2);
    for (int i = 0; i < 800; i++) begin
      logic v;
      reset   = ($urandom % 150) == 0;
      cnt_clr = ($urandom % 25) == 0;
      bp_en   = ($urandom % 3) == 0;
      bp_addr = ($urandom % 16) * 4;
      if ($urandom % 40 == 0) pc = ($urandom % 16) * 4;
      if ($urandom % 25 == 0) imem[$urandom % 64] = SYSC;
      if ($urandom % 8 == 0) imem[pc[7:2]] = NOPI;
      v = ($urandom % 4) == 0;
      cycle(v, 2'($urandom), int'($urandom % 6));
    end
    reset = 0; cnt_clr = 0;
    idle(1);
    @(negedge clk); #1;
    if (q.size() != 0) begin
      n_chk++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
